// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter and its round-robin picker.
package spram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int unsigned MAX_REQ        = 4;

    // One-hot pick of the first valid requester at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] grant;
        logic [1:0]         idx;
        grant = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = 2'((ptr + k) % n);
            if ((k < n) && (grant == '0) && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first valid requester from the pointer.
module rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant
);

    logic [MAX_REQ-1:0] w_valid;
    logic [MAX_REQ-1:0] w_grant;

    assign w_valid = MAX_REQ'(i_valid);
    assign w_grant = rr_pick(w_valid, 32'(i_ptr), NUM_REQ);
    assign o_grant = NUM_REQ'(w_grant);

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM between NUM_REQ requesters: clears the RAM after reset,
// then grants one access per cycle round-robin and steers read data back to the reader.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = $clog2(DEPTH),
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          init_done,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_data,
    input  logic [DATA_WIDTH-1:0]         ram_q
);

    localparam int unsigned PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LAST_ADDR = (2 ** ADDR_WIDTH) - 1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  r_init_done;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_addr_hold;
    logic [DATA_WIDTH-1:0] r_data_hold;
    logic                  w_run;
    logic [NUM_REQ-1:0]    w_arb_grant;
    logic [NUM_REQ-1:0]    w_grant;

    // Grants only once the clear sequence is done and never while reset is being applied.
    assign w_run = r_init_done && !rst && (r_state == ST_RUN);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_valid (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    assign w_grant   = w_arb_grant & {NUM_REQ{w_run}};
    assign req_ready = w_grant;
    assign init_done = r_init_done;
    // A response already in flight when reset arrives is dropped in that same cycle.
    assign rsp_valid = r_rsp_valid & {NUM_REQ{!rst}};
    assign rsp_rdata = ram_q;

    // State, counter, pointer and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
            r_rsp_valid <= '0;
            r_addr_hold <= '0;
            r_data_hold <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
            r_rsp_valid <= w_grant & ~req_we;
            r_addr_hold <= ram_addr;
            r_data_hold <= ram_data;
        end
    end

    // Next state and RAM drive; idle cycles replay the last address/data to avoid toggling.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        ram_we      = 1'b0;
        ram_addr    = r_addr_hold;
        ram_data    = r_data_hold;
        case (r_state)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = r_cnt;
                ram_data  = '0;
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == ADDR_WIDTH'(LAST_ADDR)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (w_grant[i]) begin
                        ram_we    = req_we[i];
                        ram_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_data  = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                        w_ptr_nxt = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural 64x8 RAM (registered read address).
module tb_spram_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              init_done;
    logic              ram_we;
    logic [AW-1:0]     ram_addr;
    logic [DW-1:0]     ram_data;
    logic [DW-1:0]     ram_q;

    typedef struct {
        int           req;
        logic [7:0]   data;
        int           cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [5:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spram_arbiter #(
        .NUM_REQ       (NR),
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_q     (ram_q)
    );

    // RAM model: synchronous write, registered read address.
    logic [DW-1:0] mem [0:63];
    logic [AW-1:0] ram_addr_q;
    initial for (int i = 0; i < 64; i++) mem[i] = 8'hEE;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_addr_q <= ram_addr;
    end
    assign ram_q = mem[ram_addr_q];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the oldest expectation whenever a response is seen or is due.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid !== 2'b00 || (sb_q.size() != 0 && sb_q[0].cyc <= cyc)) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: rsp_valid=%b with nothing expected (cycle %0d)", rsp_valid, cyc);
            end else begin
                e = sb_q.pop_front();
                if (rsp_valid !== 2'(1 << e.req) || rsp_rdata !== e.data || cyc != e.cyc) begin
                    n_errors++;
                    $display("FAIL rsp_check: got valid=%b data=0x%0h cycle=%0d, expected valid=%b data=0x%0h cycle=%0d",
                             rsp_valid, rsp_rdata, cyc, 2'(1 << e.req), e.data, e.cyc);
                end
            end
        end
    end

    // One RUN cycle: apply inputs, check grant and RAM drive, queue any read response.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [1:0] exp_rdy, input logic [7:0] exp_q);
        int         idx;
        logic       gw;
        logic [5:0] ga;
        logic [7:0] gd;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        idx = exp_rdy[1] ? 1 : 0;
        if (exp_rdy == 2'b00) begin
            gw = 1'b0;
            ga = last_addr;
            gd = last_data;
        end else begin
            gw = we[idx];
            ga = (idx == 1) ? a1 : a0;
            gd = (idx == 1) ? d1 : d0;
        end
        check("ram_drive", 32'({ram_we, ram_addr, ram_data}), 32'({gw, ga, gd}));
        last_addr = ga;
        last_data = gd;
        if (exp_rdy != 2'b00 && !gw) sb_q.push_back('{idx, exp_q, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    // Clear sweep with both requesters pushing writes that must not be granted.
    task automatic init_sweep();
        req_valid = 2'b11;
        req_we    = 2'b11;
        req_addr  = {6'h13, 6'h12};
        req_wdata = {8'h5A, 8'hA5};
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            check("init_sweep", 32'({ram_we, ram_addr, ram_data, req_ready, init_done}),
                  32'({1'b1, 6'(k), 8'h00, 2'b00, 1'b0}));
            if (k == 63) req_valid = 2'b00;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("init_done", 32'(init_done), 32'd1);
        check("run_idle_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        last_addr = 6'h3F;
        last_data = 8'h00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_sweep();

        // Single write then read by requester 0.
        step(2'b01, 2'b01, 6'h12, 6'h00, 8'hA5, 8'h00, 2'b01, 8'h00);
        step(2'b01, 2'b00, 6'h12, 6'h00, 8'h00, 8'h00, 2'b01, 8'hA5);
        step(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 2'b00, 8'h00);

        // Preload 3 and 7, then both requesters read continuously.
        step(2'b01, 2'b01, 6'h03, 6'h00, 8'h33, 8'h00, 2'b01, 8'h00);
        step(2'b10, 2'b10, 6'h00, 6'h07, 8'h00, 8'h77, 2'b10, 8'h00);
        step(2'b11, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b01, 8'h33);
        step(2'b11, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b10, 8'h77);
        step(2'b11, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b01, 8'h33);
        step(2'b11, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b10, 8'h77);
        step(2'b00, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b00, 8'h00);

        // Write-then-read and read-then-write on address 9.
        step(2'b10, 2'b10, 6'h00, 6'h09, 8'h00, 8'h5C, 2'b10, 8'h00);
        step(2'b01, 2'b00, 6'h09, 6'h00, 8'h00, 8'h00, 2'b01, 8'h5C);
        step(2'b01, 2'b00, 6'h09, 6'h00, 8'h00, 8'h00, 2'b01, 8'h5C);
        step(2'b10, 2'b10, 6'h00, 6'h09, 8'h00, 8'h11, 2'b10, 8'h00);
        step(2'b01, 2'b00, 6'h09, 6'h00, 8'h00, 8'h00, 2'b01, 8'h11);

        // Mixed contention starting from pointer 1, then requester 1 reads back the write.
        step(2'b11, 2'b01, 6'h20, 6'h09, 8'h42, 8'h00, 2'b10, 8'h11);
        step(2'b11, 2'b01, 6'h20, 6'h09, 8'h42, 8'h00, 2'b01, 8'h00);
        step(2'b10, 2'b00, 6'h00, 6'h20, 8'h00, 8'h00, 2'b10, 8'h42);

        // Requester 1 loses arbitration then withdraws: no side effect.
        step(2'b11, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b01, 8'h33);
        step(2'b00, 2'b00, 6'h03, 6'h07, 8'h00, 8'h00, 2'b00, 8'h00);

        // Top address was only ever cleared.
        step(2'b01, 2'b00, 6'h3F, 6'h00, 8'h00, 8'h00, 2'b01, 8'h00);
        step(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 2'b00, 8'h00);

        // Reset right after a read grant: the response must be discarded.
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr  = {6'h00, 6'h03};
        @(negedge clk);
        check("rst_mid_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_init_done", 32'(init_done), 32'd0);
        check("rst_mid_rsp2", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        init_sweep();

        // Re-clear wiped the earlier preload.
        step(2'b01, 2'b00, 6'h03, 6'h00, 8'h00, 8'h00, 2'b01, 8'h00);
        step(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 2'b00, 8'h00);
        step(2'b00, 2'b00, 6'h00, 6'h00, 8'h00, 8'h00, 2'b00, 8'h00);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
